// File: rtl/ssd_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver with a double-buffered digit word,
// anode ghost-blanking, per-digit blank/DP and leading-zero suppression.
module ssd_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  input  logic                      lz_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      pending,
  output logic                      frame_tick
);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h3F;  4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;  4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;  4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;  4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;  4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;  4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;  4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;  default: hex_decode = 7'h71;
    endcase
  endfunction

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_blank_q, disp_dp_q, disp_blank_q;
  logic                    pending_q, pending_d, frame_tick_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    div_wrap, idx_last, boundary, all_zero, digit_dark, ghost;
  logic [NUM_DIGITS-1:0]   lz_mask, onehot;
  logic [3:0]              nibble;
  logic [6:0]              seg_raw;

  always_comb begin
    div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));
    idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
    boundary = div_wrap && idx_last;
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    idx_d    = idx_q;
    if (div_wrap) idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    pending_d = load ? 1'b1 : (boundary ? 1'b0 : pending_q);

    // Walk from the most significant digit down; digit 0 is never suppressed.
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero   = all_zero && (disp_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = lz_en && all_zero;
    end

    nibble     = disp_val_q[4*idx_q +: 4];
    digit_dark = disp_blank_q[idx_q] | lz_mask[idx_q];
    ghost      = int'(div_q) < BLANK_CYCLES;
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
    seg_raw    = digit_dark ? 7'h00 : hex_decode(nibble);
    seg_d      = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d       = (!digit_dark && disp_dp_q[idx_q]) ^ SEG_ACTIVE_LOW;
    an_d       = (digit_dark || ghost) ? AN_OFF : (AN_ACTIVE_LOW ? ~onehot : onehot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q          <= '0;
      idx_q          <= '0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      disp_val_q     <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '1;
      pending_q      <= 1'b0;
      frame_tick_q   <= 1'b0;
      seg_q          <= SEG_OFF;
      dp_q           <= DP_OFF;
      an_q           <= AN_OFF;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      frame_tick_q <= boundary;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      // Commit reads the pre-edge shadow, so a load on this same edge waits a frame.
      if (boundary && pending_q) begin
        disp_val_q   <= shadow_val_q;
        disp_dp_q    <= shadow_dp_q;
        disp_blank_q <= shadow_blank_q;
      end
      if (load) begin
        shadow_val_q   <= value;
        shadow_dp_q    <= dp_in;
        shadow_blank_q <= blank_in;
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: cycle-count based behavioural model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ssd_scan_driver;
  logic        clk, rst, load, lz_en;
  logic [15:0] value;
  logic [3:0]  dp_in, blank_in;
  logic [6:0]  seg;
  logic        dp, pending, frame_tick;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  ssd_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an),
    .pending(pending), .frame_tick(frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: slot/phase derived from a cycle count since reset.
  logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit          model_ok = 1'b0;
  int          cnt, slot, ph;
  logic [15:0] sh_v, ds_v;
  logic [3:0]  sh_dp, sh_bl, ds_dp, ds_bl, nib;
  bit          pend, lzb, blk, bnd;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;
  logic [3:0]  e_an;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1'b1;
      cnt = 0; pend = 1'b0;
      sh_v = '0; sh_dp = '0; sh_bl = '0;
      ds_v = '0; ds_dp = '0; ds_bl = 4'hF;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_ft = 1'b0;
    end else if (model_ok) begin
      slot = (cnt / 4) % 4;
      ph   = cnt % 4;
      bnd  = (cnt % 16) == 15;
      nib  = ds_v[slot*4 +: 4];
      lzb  = lz_en && slot > 0 && ((ds_v >> (slot*4)) == 16'h0);
      blk  = ds_bl[slot] || lzb;
      if (blk) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        e_seg = ~HEX[nib];
        e_dp  = ~ds_dp[slot];
        e_an  = (ph < 1) ? 4'hF : ~(4'b0001 << slot);
      end
      e_ft = bnd;
      if (bnd && pend) begin
        ds_v = sh_v; ds_dp = sh_dp; ds_bl = sh_bl; pend = 1'b0;
      end
      if (load) begin
        sh_v = value; sh_dp = dp_in; sh_bl = blank_in; pend = 1'b1;
      end
      cnt++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_seg", 32'(seg), 32'(e_seg));
      chk("m_dp", 32'(dp), 32'(e_dp));
      chk("m_an", 32'(an), 32'(e_an));
      chk("m_pending", 32'(pending), 32'(pend));
      chk("m_frame_tick", 32'(frame_tick), 32'(e_ft));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 64);
    chk("tick_seen", 32'(frame_tick), 32'h1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank_in = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    step(3);
    rst = 1'b0;

    // 1: idle after reset, display blank
    step(20);
    chk("idle_seg", 32'(seg), 32'h7F);
    chk("idle_an", 32'(an), 32'hF);
    chk("idle_dp", 32'(dp), 32'h1);
    chk("idle_pending", 32'(pending), 32'h0);
    wait_tick(n);
    wait_tick(n);
    chk("tick_period", 32'(n), 32'd16);

    // 2: mid-frame load, commit at boundary
    step(3);
    do_load(16'h12AF, 4'h0, 4'h0);
    chk("t2_pending_set", 32'(pending), 32'h1);
    wait_tick(n);
    chk("t2_pending_clr", 32'(pending), 32'h0);
    step(1);
    chk("t2_d0_ghost_an", 32'(an), 32'hF);
    step(1);
    chk("t2_d0_an", 32'(an), 32'hE);
    chk("t2_d0_seg", 32'(seg), 32'h0E);
    step(11);
    chk("t2_d3_ghost_an", 32'(an), 32'hF);
    step(1);
    chk("t2_d3_an", 32'(an), 32'h7);
    chk("t2_d3_seg", 32'(seg), 32'h79);

    // 3: two loads in one frame, last wins
    wait_tick(n);
    step(2);
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0);
    wait_tick(n);
    chk("t3_pending_clr", 32'(pending), 32'h0);
    step(2);
    chk("t3_seg", 32'(seg), 32'h24);
    chk("t3_an", 32'(an), 32'hE);

    // 4: leading-zero suppression
    lz_en = 1'b1;
    wait_tick(n);
    step(2);
    do_load(16'h0050, 4'h0, 4'h0);
    wait_tick(n);
    step(2);
    chk("t4_d0_seg", 32'(seg), 32'h40);
    chk("t4_d0_an", 32'(an), 32'hE);
    step(4);
    chk("t4_d1_seg", 32'(seg), 32'h12);
    chk("t4_d1_an", 32'(an), 32'hD);
    step(4);
    chk("t4_d2_an", 32'(an), 32'hF);
    chk("t4_d2_seg", 32'(seg), 32'h7F);
    step(4);
    chk("t4_d3_an", 32'(an), 32'hF);
    lz_en = 1'b0;

    // 5: load exactly on the boundary edge
    wait_tick(n);
    step(2);
    do_load(16'h3333, 4'h0, 4'h0);
    step(12);
    value = 16'h4444; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t5_tick", 32'(frame_tick), 32'h1);
    chk("t5_pending_kept", 32'(pending), 32'h1);
    step(2);
    chk("t5_old_seg", 32'(seg), 32'h30);
    step(10);
    chk("t5_pending_mid", 32'(pending), 32'h1);
    wait_tick(n);
    chk("t5_pending_clr", 32'(pending), 32'h0);
    step(2);
    chk("t5_new_seg", 32'(seg), 32'h19);

    // 6: reset during digit-2 slot with a pending load
    wait_tick(n);
    step(9);
    do_load(16'h5555, 4'hF, 4'h0);
    chk("t6_pending_set", 32'(pending), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_seg", 32'(seg), 32'h7F);
    chk("t6_an", 32'(an), 32'hF);
    chk("t6_dp", 32'(dp), 32'h1);
    chk("t6_pending", 32'(pending), 32'h0);
    chk("t6_tick", 32'(frame_tick), 32'h0);
    rst = 1'b0;
    wait_tick(n);
    chk("t6_first_frame_len", 32'(n), 32'd16);
    step(2);
    chk("t6_dark_an", 32'(an), 32'hF);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
